bool_equiv_sweeper: RTL and testbench

Sequential equivalence checker for small combinational circuits built in the DLD lab flow. It replaces hand-written exhaustive `initial` stimulus blocks. The block drives every N-bit input combination in ascending order onto an external circuit that has two outputs, such as an original expression and its simplified form. After a settle delay it samples both outputs, compares them, and reports whether they are equivalent, how many minterms differ, and the first differing minterm. It sits beside the circuit under test, at testbench or board-top level.

---
 rtl/bool_equiv_pkg.sv | 14 +
 rtl/bool_equiv_sweeper_settle_timer.sv | 27 ++
 rtl/bool_equiv_sweeper.sv | 116 +++++++++++
 tb/tb_bool_equiv_sweeper.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bool_equiv_pkg.sv
// Shared types and limits for the boolean equivalence sweeper.
package bool_equiv_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_e;

  localparam int N_MAX      = 8;
  localparam int SETTLE_MAX = 15;

  // Width of a counter that must reach settle-1; never narrower than 1 bit.
  function automatic int settle_cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/bool_equiv_sweeper_settle_timer.sv
// Settle timer: counts cycles while enabled, flags the last settle cycle.
module settle_timer
  import bool_equiv_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_expired
);

  localparam int           W    = settle_cnt_w(SETTLE);
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);

  logic [W-1:0] r_cnt;

  assign o_expired = (r_cnt == LAST);

  // Count up from zero, hold at the last value until cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_cnt <= '0;
    else if (i_clear)   r_cnt <= '0;
    else if (!o_expired) r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/bool_equiv_sweeper.sv
// Exhaustive two-output equivalence sweeper: walks every minterm in
// ascending order, compares both circuit outputs after a settle delay,
// and reports equality, mismatch count and lowest differing minterm.
module bool_equiv_sweeper
  import bool_equiv_pkg::*;
#(
  parameter int N          = 3,
  parameter int SETTLE     = 1,
  parameter bit STOP_FIRST = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_lhs_in,
  input  logic         i_rhs_in,
  output logic [N-1:0] o_stim,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_equal,
  output logic [N:0]   o_mismatch_count,
  output logic [N-1:0] o_first_mismatch,
  output logic         o_first_valid
);

  localparam logic [N-1:0] STIM_LAST = '1;

  state_e       r_state, w_state_nxt;
  logic [N-1:0] r_stim;
  logic [N:0]   r_cnt;
  logic [N:0]   w_cnt_nxt;
  logic [N-1:0] r_first;
  logic         r_first_valid;
  logic         r_equal;
  logic         w_expired;
  logic         w_clear;
  logic         w_mis;
  logic         w_last;
  logic         w_end;

  // Timer only runs while a minterm is being applied.
  assign w_clear = (r_state != APPLY);

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_clear),
    .o_expired (w_expired)
  );

  // Outputs are taken combinationally in the SAMPLE cycle only.
  assign w_mis     = (r_state == SAMPLE) && (i_lhs_in != i_rhs_in);
  assign w_last    = (r_stim == STIM_LAST);
  assign w_end     = w_last || (STOP_FIRST && w_mis);
  assign w_cnt_nxt = r_cnt + (N+1)'(w_mis);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start)   w_state_nxt = APPLY;
      APPLY:   if (w_expired) w_state_nxt = SAMPLE;
      SAMPLE:  w_state_nxt = w_end ? DONE : APPLY;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stimulus and result registers. equal is loaded on the edge into DONE
  // from the final count so it is already valid while done is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stim        <= '0;
      r_cnt         <= '0;
      r_first       <= '0;
      r_first_valid <= 1'b0;
      r_equal       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_stim        <= '0;
            r_cnt         <= '0;
            r_first       <= '0;
            r_first_valid <= 1'b0;
            r_equal       <= 1'b0;
          end
        end
        SAMPLE: begin
          r_cnt <= w_cnt_nxt;
          if (w_mis && !r_first_valid) begin
            r_first       <= r_stim;
            r_first_valid <= 1'b1;
          end
          if (w_end) r_equal <= (w_cnt_nxt == '0);
          else       r_stim  <= r_stim + N'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_stim           = r_stim;
  assign o_busy           = (r_state == APPLY) || (r_state == SAMPLE);
  assign o_done           = (r_state == DONE);
  assign o_equal          = r_equal;
  assign o_mismatch_count = r_cnt;
  assign o_first_mismatch = r_first;
  assign o_first_valid    = r_first_valid;

endmodule

// File: tb/tb_bool_equiv_sweeper.sv
// Directed bench: three sweeper instances (N=3 SETTLE=1, N=3 SETTLE=3
// stop-first, N=8 all-mismatch) driving small combinational pairs.
module tb_bool_equiv_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [2:0] start;
  int         sel;

  // Instance A: N=3, SETTLE=1
  logic       a_lhs, a_rhs, a_busy, a_done, a_equal, a_fv;
  logic [2:0] a_stim, a_first;
  logic [3:0] a_cnt;
  // Instance B: N=3, SETTLE=3, STOP_FIRST=1
  logic       b_lhs, b_rhs, b_busy, b_done, b_equal, b_fv;
  logic [2:0] b_stim, b_first;
  logic [3:0] b_cnt;
  // Instance C: N=8, SETTLE=1
  logic       c_lhs, c_rhs, c_busy, c_done, c_equal, c_fv;
  logic [7:0] c_stim, c_first;
  logic [8:0] c_cnt;

  // Circuit A: sel 0 -> a'+abc+ab'c vs a'+c ; sel 1 -> a'+c vs a'+b
  always_comb begin
    if (sel == 0) begin
      a_lhs = ~a_stim[2] | (a_stim[2] & a_stim[1] & a_stim[0]) | (a_stim[2] & ~a_stim[1] & a_stim[0]);
      a_rhs = ~a_stim[2] | a_stim[0];
    end else begin
      a_lhs = ~a_stim[2] | a_stim[0];
      a_rhs = ~a_stim[2] | a_stim[1];
    end
  end
  assign b_lhs = ~b_stim[2] | b_stim[0];
  assign b_rhs = ~b_stim[2] | b_stim[1];
  assign c_lhs = 1'b0;
  assign c_rhs = 1'b1;

  bool_equiv_sweeper #(.N(3), .SETTLE(1), .STOP_FIRST(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_lhs_in(a_lhs), .i_rhs_in(a_rhs),
    .o_stim(a_stim), .o_busy(a_busy), .o_done(a_done), .o_equal(a_equal),
    .o_mismatch_count(a_cnt), .o_first_mismatch(a_first), .o_first_valid(a_fv));

  bool_equiv_sweeper #(.N(3), .SETTLE(3), .STOP_FIRST(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_lhs_in(b_lhs), .i_rhs_in(b_rhs),
    .o_stim(b_stim), .o_busy(b_busy), .o_done(b_done), .o_equal(b_equal),
    .o_mismatch_count(b_cnt), .o_first_mismatch(b_first), .o_first_valid(b_fv));

  bool_equiv_sweeper #(.N(8), .SETTLE(1), .STOP_FIRST(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_lhs_in(c_lhs), .i_rhs_in(c_rhs),
    .o_stim(c_stim), .o_busy(c_busy), .o_done(c_done), .o_equal(c_equal),
    .o_mismatch_count(c_cnt), .o_first_mismatch(c_first), .o_first_valid(c_fv));

  // Count done cycles of instance A that reach a clock edge.
  int dcnt_a = 0;
  always @(posedge clk) if (a_done) dcnt_a <= dcnt_a + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic dn(input int d);
    case (d)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic bz(input int d);
    case (d)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  // Start a sweep from IDLE (called at a negedge); returns edges from the
  // accepting edge to the DONE cycle, sampled at negedges.
  task automatic sweep(input int d, input bit hold, output int edges);
    start[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start[d] = 1'b0;
    chk("busy_after_start", 32'(bz(d)), 32'd1);
    edges = 0;
    while (!dn(d) && edges < 2000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  int e;
  int pre;

  initial begin
    start = '0;
    sel   = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_a_stim",  32'(a_stim), 32'd0);
    chk("rst_a_flags", 32'({a_busy, a_done, a_equal, a_fv}), 32'd0);
    chk("rst_a_cnt",   32'(a_cnt), 32'd0);
    chk("rst_a_first", 32'(a_first), 32'd0);
    chk("rst_c_state", 32'({c_busy, c_done, c_equal, c_fv, c_cnt, c_stim}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Equivalent pair
    sel = 0;
    sweep(0, 1'b0, e);
    chk("eq_latency", 32'(e), 32'd16);
    chk("eq_equal",   32'(a_equal), 32'd1);
    chk("eq_count",   32'(a_cnt), 32'd0);
    chk("eq_fv",      32'(a_fv), 32'd0);
    chk("eq_first",   32'(a_first), 32'd0);
    chk("eq_stim",    32'(a_stim), 32'd7);
    @(negedge clk);
    chk("eq_done_pulse", 32'({a_done, a_busy}), 32'd0);
    chk("eq_equal_hold", 32'(a_equal), 32'd1);

    // Non-equivalent pair
    sel = 1;
    sweep(0, 1'b0, e);
    chk("ne_latency", 32'(e), 32'd16);
    chk("ne_count",   32'(a_cnt), 32'd2);
    chk("ne_first",   32'(a_first), 32'd5);
    chk("ne_fv",      32'(a_fv), 32'd1);
    chk("ne_equal",   32'(a_equal), 32'd0);
    @(negedge clk);

    // Stop at first mismatch, SETTLE=3
    sweep(1, 1'b0, e);
    chk("sf_latency", 32'(e), 32'd24);
    chk("sf_count",   32'(b_cnt), 32'd1);
    chk("sf_first",   32'(b_first), 32'd5);
    chk("sf_fv",      32'(b_fv), 32'd1);
    chk("sf_equal",   32'(b_equal), 32'd0);
    chk("sf_stim",    32'(b_stim), 32'd5);
    @(negedge clk);

    // All-mismatch, N=8
    sweep(2, 1'b0, e);
    chk("am_latency", 32'(e), 32'd512);
    chk("am_count",   32'(c_cnt), 32'h100);
    chk("am_first",   32'(c_first), 32'd0);
    chk("am_fv",      32'(c_fv), 32'd1);
    chk("am_equal",   32'(c_equal), 32'd0);
    @(negedge clk);

    // Reset during APPLY of minterm 4
    sel = 1;
    pre = dcnt_a;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mr_stim_before", 32'(a_stim), 32'd4);
    chk("mr_busy_before", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_state_async", 32'({a_busy, a_done, a_equal, a_fv, a_cnt, a_first, a_stim}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mr_no_done", 32'(dcnt_a - pre), 32'd0);
    @(negedge clk);
    sweep(0, 1'b0, e);
    chk("mr_latency", 32'(e), 32'd16);
    chk("mr_count",   32'(a_cnt), 32'd2);
    chk("mr_first",   32'(a_first), 32'd5);
    @(negedge clk);

    // start held high: back-to-back sweeps with one IDLE cycle between
    sweep(0, 1'b1, e);
    chk("bb1_latency", 32'(e), 32'd16);
    chk("bb1_stim",    32'(a_stim), 32'd7);
    chk("bb1_results", 32'({a_equal, a_fv, a_first, a_cnt}), 32'({1'b0, 1'b1, 3'd5, 4'd2}));
    @(negedge clk);
    chk("bb_idle_gap", 32'({a_busy, a_done}), 32'd0);
    @(negedge clk);
    chk("bb_restart", 32'({a_busy, a_stim}), 32'({1'b1, 3'd0}));
    e = 2;
    while (!a_done && e < 200) begin
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    chk("bb2_spacing", 32'(e), 32'd18);
    chk("bb2_stim",    32'(a_stim), 32'd7);
    chk("bb2_results", 32'({a_equal, a_fv, a_first, a_cnt}), 32'({1'b0, 1'b1, 3'd5, 4'd2}));
    start[0] = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
